hazard_fwd_ctrl: RTL and testbench

//  Pipeline controller for the execute-stage datapath. Tracks the destination register of in-flight

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/fwd_match.sv | 46 ++++
 rtl/hazard_fwd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the execute-stage hazard/forwarding controller:
// writeback-source codes, forward-word bit positions and controller states.
package hazard_pkg;

    // Writeback source of an instruction (also the low two bits of a forward word).
    typedef enum logic [1:0] {
        WB_ADDPC = 2'b00,
        WB_MEM   = 2'b01,
        WB_ALU   = 2'b10,
        WB_IMM8  = 2'b11
    } wb_sel_e;

    // Forward word layout: [5:4] reserved, [3] enable, [2] 0=X2X/1=M2X, [1:0] producer wbSel.
    localparam int FW_W   = 6;
    localparam int FW_EN  = 3;
    localparam int FW_M2X = 2;

    // Controller states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

endpackage

// File: rtl/fwd_match.sv
// Combinational operand-source matcher: compares one ID source register
// against the EX and MEM shadow entries and builds the forward word.
// The nearer producer (EX) wins; an EX producer that is a load cannot be
// forwarded yet and raises loadUse instead of a forward word.
module fwd_match import hazard_pkg::*; #(
    parameter int REG_W = 3
) (
    input  logic [REG_W-1:0] src,
    input  logic             srcUse,
    input  logic             exValid,
    input  logic [REG_W-1:0] exRd,
    input  logic             exRegWrite,
    input  logic [1:0]       exWbSel,
    input  logic             memValid,
    input  logic [REG_W-1:0] memRd,
    input  logic             memRegWrite,
    input  logic [1:0]       memWbSel,
    output logic [FW_W-1:0]  fwWord,
    output logic             loadUse
);

    logic exHit;
    logic memHit;

    assign exHit  = srcUse & exValid  & exRegWrite  & (exRd  == src);
    assign memHit = srcUse & memValid & memRegWrite & (memRd == src);

    // Priority select: EX producer first, then MEM, otherwise register file.
    always_comb begin
        fwWord  = '0;
        loadUse = 1'b0;
        if (exHit) begin
            if (exWbSel == WB_MEM) begin
                loadUse = 1'b1;
            end else begin
                fwWord[FW_EN] = 1'b1;
                fwWord[1:0]   = exWbSel;
            end
        end else if (memHit) begin
            fwWord[FW_EN]  = 1'b1;
            fwWord[FW_M2X] = 1'b1;
            fwWord[1:0]    = memWbSel;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Execute-stage pipeline controller: tracks destination registers of the
// instructions in EX and MEM, registers the forward words for the operands
// of the instruction entering EX, stalls one cycle on a load-use hazard and
// inserts FLUSH_CYCLES bubbles after a taken branch/jump.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_fwd_ctrl import hazard_pkg::*; #(
    parameter int REG_W        = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idValid,
    input  logic [REG_W-1:0] idRsA,
    input  logic [REG_W-1:0] idRsB,
    input  logic             idUseA,
    input  logic             idUseB,
    input  logic [REG_W-1:0] idRd,
    input  logic             idRegWrite,
    input  logic [1:0]       idWbSel,
    input  logic             exRedirect,
    output logic [5:0]       fwCntrlA,
    output logic [5:0]       fwCntrlB,
    output logic             stallIF,
    output logic             bubbleEX,
    output logic             flushID
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]      stallCnt,
    output logic [15:0]      flushCnt
`endif
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [CNT_W-1:0] fcnt_q;
    logic [CNT_W-1:0] fcnt_d;
    logic             bubbleNext;

    // EX shadow (_p1) and MEM shadow (_p2) of the in-flight instructions.
    logic             shValid_p1;
    logic [REG_W-1:0] shRd_p1;
    logic             shRegWrite_p1;
    logic [1:0]       shWbSel_p1;
    logic             shValid_p2;
    logic [REG_W-1:0] shRd_p2;
    logic             shRegWrite_p2;
    logic [1:0]       shWbSel_p2;

    logic [FW_W-1:0]  wordA;
    logic [FW_W-1:0]  wordB;
    logic             luA;
    logic             luB;
    logic             loadUse;

    fwd_match #(.REG_W(REG_W)) u_match_a (
        .src         (idRsA),
        .srcUse      (idValid & idUseA),
        .exValid     (shValid_p1),
        .exRd        (shRd_p1),
        .exRegWrite  (shRegWrite_p1),
        .exWbSel     (shWbSel_p1),
        .memValid    (shValid_p2),
        .memRd       (shRd_p2),
        .memRegWrite (shRegWrite_p2),
        .memWbSel    (shWbSel_p2),
        .fwWord      (wordA),
        .loadUse     (luA)
    );

    fwd_match #(.REG_W(REG_W)) u_match_b (
        .src         (idRsB),
        .srcUse      (idValid & idUseB),
        .exValid     (shValid_p1),
        .exRd        (shRd_p1),
        .exRegWrite  (shRegWrite_p1),
        .exWbSel     (shWbSel_p1),
        .memValid    (shValid_p2),
        .memRd       (shRd_p2),
        .memRegWrite (shRegWrite_p2),
        .memWbSel    (shWbSel_p2),
        .fwWord      (wordB),
        .loadUse     (luB)
    );

    assign loadUse = luA | luB;

    // Next state, flush down-counter and state-decoded control outputs.
    // A redirect overrides everything, including a load-use seen in the same cycle.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        stallIF  = (state_q == STALL);
        flushID  = (state_q == FLUSH);
        bubbleEX = (state_q != RUN);
        if (exRedirect) begin
            state_d = FLUSH;
            fcnt_d  = CNT_W'(FLUSH_CYCLES);
        end else begin
            case (state_q)
                RUN:     if (loadUse) state_d = STALL;
                STALL:   state_d = RUN;
                FLUSH: begin
                    if (fcnt_q <= CNT_W'(1)) state_d = RUN;
                    else                      fcnt_d  = fcnt_q - CNT_W'(1);
                end
                default: state_d = RUN;
            endcase
        end
        // The instruction leaving ID this cycle is replaced by a bubble whenever
        // the controller is heading into STALL or FLUSH.
        bubbleNext = (state_d != RUN);
    end

    // ---- ID -> EX/MEM boundary: control state, shadow valids and forward words ----
    // Registered forward words are forced to zero for the cycles EX holds a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            fcnt_q     <= '0;
            shValid_p1 <= 1'b0;
            shValid_p2 <= 1'b0;
            fwCntrlA   <= '0;
            fwCntrlB   <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            shValid_p1 <= idValid & ~bubbleNext;
            shValid_p2 <= shValid_p1;
            fwCntrlA   <= bubbleNext ? '0 : wordA;
            fwCntrlB   <= bubbleNext ? '0 : wordB;
        end
    end

    // Shadow payload advances every cycle; it is only meaningful under its valid.
    always_ff @(posedge clk) begin
        shRd_p1       <= idRd;
        shRegWrite_p1 <= idRegWrite;
        shWbSel_p1    <= idWbSel;
        shRd_p2       <= shRd_p1;
        shRegWrite_p2 <= shRegWrite_p1;
        shWbSel_p2    <= shWbSel_p1;
    end

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Performance counters: cycles spent stalled and number of flush entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (state_q == STALL) stallCnt <= sat_inc(stallCnt);
            if (exRedirect)       flushCnt <= sat_inc(flushCnt);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios followed by
// randomized traffic, checked against a slot-based reference model.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       idValid = 1'b0;
    logic [2:0] idRsA = '0;
    logic [2:0] idRsB = '0;
    logic       idUseA = 1'b0;
    logic       idUseB = 1'b0;
    logic [2:0] idRd = '0;
    logic       idRegWrite = 1'b0;
    logic [1:0] idWbSel = '0;
    logic       exRedirect = 1'b0;
    wire  [5:0] fwCntrlA;
    wire  [5:0] fwCntrlB;
    wire        stallIF;
    wire        bubbleEX;
    wire        flushID;
`ifdef HAZ_PERF_CNT_EN
    wire [15:0] stallCnt;
    wire [15:0] flushCnt;
`endif

    hazard_fwd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .idValid    (idValid),
        .idRsA      (idRsA),
        .idRsB      (idRsB),
        .idUseA     (idUseA),
        .idUseB     (idUseB),
        .idRd       (idRd),
        .idRegWrite (idRegWrite),
        .idWbSel    (idWbSel),
        .exRedirect (exRedirect),
        .fwCntrlA   (fwCntrlA),
        .fwCntrlB   (fwCntrlB),
        .stallIF    (stallIF),
        .bubbleEX   (bubbleEX),
        .flushID    (flushID)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stallCnt   (stallCnt),
        .flushCnt   (flushCnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what instruction occupies each later stage, plus mode.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        int wb;
    } slot_t;

    slot_t m_ex;
    slot_t m_mem;
    int    m_mode = 0;   // 0 running, 1 stalled, 2 flushing
    int    m_left = 0;   // flush cycles still to go
    int    m_fwA  = 0;
    int    m_fwB  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Forward word for one source: nearest older writer of the register decides.
    function automatic int fwd(input int src, input bit u, output bit lu);
        lu = 1'b0;
        if (u && m_ex.v && m_ex.rw && m_ex.rd == src) begin
            if (m_ex.wb == 1) begin
                lu = 1'b1;
                return 0;
            end
            return 8 + m_ex.wb;             // enable, X2X
        end
        if (u && m_mem.v && m_mem.rw && m_mem.rd == src)
            return 8 + 4 + m_mem.wb;        // enable, M2X
        return 0;
    endfunction

    task automatic model_reset();
        m_ex   = '{v: 1'b0, rd: 0, rw: 1'b0, wb: 0};
        m_mem  = '{v: 1'b0, rd: 0, rw: 1'b0, wb: 0};
        m_mode = 0;
        m_left = 0;
        m_fwA  = 0;
        m_fwB  = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_fwA"},   fwCntrlA, m_fwA);
        chk({tag, "_fwB"},   fwCntrlB, m_fwB);
        chk({tag, "_stall"}, stallIF,  (m_mode == 1) ? 1 : 0);
        chk({tag, "_bub"},   bubbleEX, (m_mode != 0) ? 1 : 0);
        chk({tag, "_flush"}, flushID,  (m_mode == 2) ? 1 : 0);
    endtask

    // Advance one clock with the inputs currently driven, update model, compare.
    task automatic step(input string tag);
        bit la, lb, bub;
        int fa, fb, nmode, nleft;
        fa = fwd(idRsA, idValid && idUseA, la);
        fb = fwd(idRsB, idValid && idUseB, lb);
        nmode = m_mode;
        nleft = m_left;
        if (exRedirect) begin
            nmode = 2;
            nleft = 2;
        end else if (m_mode == 0 && (la || lb)) begin
            nmode = 1;
        end else if (m_mode == 1) begin
            nmode = 0;
        end else if (m_mode == 2) begin
            nleft = m_left - 1;
            if (nleft == 0) nmode = 0;
        end
        bub = (nmode != 0);
        @(posedge clk);
        #1;
        m_mem  = m_ex;
        m_ex   = '{v: idValid && !bub, rd: int'(idRd), rw: idRegWrite, wb: int'(idWbSel)};
        m_fwA  = bub ? 0 : fa;
        m_fwB  = bub ? 0 : fb;
        m_mode = nmode;
        m_left = nleft;
        check_all(tag);
    endtask

    task automatic put(input bit v, input int ra, input bit ua, input int rb, input bit ub,
                       input int rd, input bit rw, input int wb, input bit redir);
        idValid    = v;
        idRsA      = 3'(ra);
        idUseA     = ua;
        idRsB      = 3'(rb);
        idUseB     = ub;
        idRd       = 3'(rd);
        idRegWrite = rw;
        idWbSel    = 2'(wb);
        exRedirect = redir;
    endtask

    task automatic drain();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drain");
        step("drain");
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // 1: ADD r1 ; ADD r2,r1,r3 -> X2X ALU on A, no stall
        put(1, 0, 0, 0, 0, 1, 1, 2, 0);  step("t1_p");
        put(1, 1, 1, 3, 1, 2, 1, 2, 0);  step("t1_c");
        chk("t1_fwA_lit", fwCntrlA, 6'b001010);
        chk("t1_stall_lit", stallIF, 1'b0);
        drain();

        // 2: ADD r1 ; NOP ; SUB r4,r5,r1 -> M2X ALU on B ; then with LBI producer
        put(1, 0, 0, 0, 0, 1, 1, 2, 0);  step("t2_p");
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("t2_n");
        put(1, 5, 1, 1, 1, 4, 1, 2, 0);  step("t2_c");
        chk("t2_fwB_alu", fwCntrlB, 6'b001110);
        put(1, 0, 0, 0, 0, 1, 1, 3, 0);  step("t2_lp");
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("t2_ln");
        put(1, 5, 1, 1, 1, 4, 1, 2, 0);  step("t2_lc");
        chk("t2_fwB_imm", fwCntrlB, 6'b001111);
        drain();

        // 3: LD r2 ; ADD r3,r2,r2 -> one stall cycle, then M2X mem on both
        put(1, 0, 0, 0, 0, 2, 1, 1, 0);  step("t3_ld");
        put(1, 2, 1, 2, 1, 3, 1, 2, 0);  step("t3_det");
        chk("t3_stall_lit", stallIF, 1'b1);
        chk("t3_bub_lit", bubbleEX, 1'b1);
        chk("t3_fwA_zero", fwCntrlA, 6'b0);
        step("t3_re");
        chk("t3_fwA_lit", fwCntrlA, 6'b001101);
        chk("t3_fwB_lit", fwCntrlB, 6'b001101);
        chk("t3_run_lit", stallIF, 1'b0);
        drain();

        // 4: EX and MEM both write r1 -> X2X wins
        put(1, 0, 0, 0, 0, 1, 1, 2, 0);  step("t4_m");
        put(1, 0, 0, 0, 0, 1, 1, 3, 0);  step("t4_x");
        put(1, 1, 1, 0, 0, 6, 1, 2, 0);  step("t4_c");
        chk("t4_fwA_lit", fwCntrlA, 6'b001011);
        drain();

        // 5: redirect together with load-use -> FLUSH for 2 cycles, RUN on the third
        put(1, 0, 0, 0, 0, 2, 1, 1, 0);  step("t5_ld");
        put(1, 2, 1, 0, 0, 3, 1, 2, 1);  step("t5_f1");
        chk("t5_flush1", flushID, 1'b1);
        chk("t5_nostall", stallIF, 1'b0);
        put(1, 2, 1, 0, 0, 3, 1, 2, 0);  step("t5_f2");
        chk("t5_flush2", flushID, 1'b1);
        chk("t5_fw0", fwCntrlA, 6'b0);
        step("t5_run");
        chk("t5_run_flush", flushID, 1'b0);
        chk("t5_run_bub", bubbleEX, 1'b0);
        drain();

        // 6: reset dropped mid-flush -> outputs clear immediately
        put(1, 0, 0, 0, 0, 2, 1, 1, 1);  step("t6_f");
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        repeat (2) @(posedge clk);
        #1;
        check_all("t6_held");
`ifdef HAZ_PERF_CNT_EN
        chk("t6_stallCnt", stallCnt, 16'd0);
        chk("t6_flushCnt", flushCnt, 16'd0);
`endif
        rst = 1'b1;
        step("t6_rel");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            put($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
